// File: rtl/fp_div_nr.sv
`default_nettype none
// ============================================================================
//  Module   : fp_div_nr
//  Purpose  : IEEE-754 binary32 divider, round-toward-zero, built on a
//             Newton-Raphson reciprocal of the divisor significand followed
//             by a quotient multiply. Fixed latency of 4+2*ITERATIONS cycles
//             from the start edge to done_o, special operands included.
//             Subnormal inputs and results are flushed to signed zero.
//  Ports    : clk_i      in   1  clock, rising edge
//             reset_i    in   1  synchronous active-high reset
//             start_i    in   1  start pulse, operands captured in IDLE
//             a_i        in  32  dividend (binary32)
//             b_i        in  32  divisor  (binary32)
//             result_o   out 32  quotient a_i/b_i, RTZ, held until next done
//             done_o     out  1  one-cycle pulse, result_o valid
//  Params   : ITERATIONS  Newton-Raphson refinements, 3..4
//  Macro    : FP_DIV_NR_CORRECT_EN  enables the remainder-based correction
//             step (exact RTZ). Without it the result is exact or one ulp
//             smaller in magnitude.
//  Revision : 1.0  initial release
// ============================================================================
module fp_div_nr #(
  parameter int ITERATIONS = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        done_o
);

  // Reciprocal held as unsigned Q2.40 (x lies in (0.9, 2]).
  localparam int FB = 40;
  localparam int XW = FB + 2;

  localparam logic [XW-1:0] C_SEED_A  = XW'((64'd48 << FB) / 64'd17);
  localparam logic [XW-1:0] C_SEED_B  = XW'((64'd32 << FB) / 64'd17);
  localparam logic [XW-1:0] C_TWO     = {2'b10, {FB{1'b0}}};
  localparam logic [2:0]    C_ITER_LAST = 3'(2 * ITERATIONS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEED = 3'd1,
    ITER = 3'd2,
    QMUL = 3'd3,
    CORR = 3'd4,
    PACK = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic [XW-1:0] r_x;
  logic [XW-1:0] r_t;
  logic [2:0]    r_cnt;
  logic [24:0]   r_q;
  logic [24:0]   r_qc;
  logic [31:0]   r_result;
  logic          r_done;

  // --------------------------------------------------------------------------
  // Significands. The divisor significand m is 1.fb scaled by 1/2 into
  // [0.5,1), i.e. the 24-bit integer {1,fb} read with 24 fractional bits.
  // --------------------------------------------------------------------------
  logic [23:0] w_ma;
  logic [23:0] w_mb;
  assign w_ma = {1'b1, r_a[22:0]};
  assign w_mb = {1'b1, r_b[22:0]};

  // Linear seed x0 = 48/17 - 32/17*m.
  logic [65:0]   w_seed_prod;
  logic [XW-1:0] w_seed;
  assign w_seed_prod = 66'(C_SEED_B) * 66'(w_mb);
  assign w_seed      = C_SEED_A - XW'(w_seed_prod >> 24);

  // First half of an iteration: t = 2 - m*x. m*x is rounded up so that t,
  // and hence the refined x, never exceeds the ideal value; x therefore
  // stays at or below 1/m and the quotient estimate never overshoots.
  logic [65:0]   w_mx_prod;
  logic [XW-1:0] w_mx_ceil;
  logic [XW-1:0] w_t;
  assign w_mx_prod = 66'(w_mb) * 66'(r_x);
  assign w_mx_ceil = XW'(w_mx_prod >> 24) + XW'(|w_mx_prod[23:0]);
  assign w_t       = C_TWO - w_mx_ceil;

  // Second half: x = x * t, truncated.
  logic [83:0]   w_xt_prod;
  logic [XW-1:0] w_x_next;
  assign w_xt_prod = 84'(r_x) * 84'(r_t);
  assign w_x_next  = XW'(w_xt_prod >> FB);

  // Quotient ma/mb = ma * 2^-24 * x. Kept as Q1.24 (value < 2), floor.
  logic [65:0] w_q_prod;
  logic [24:0] w_q_floor;
  assign w_q_prod  = 66'(w_ma) * 66'(r_x);
  assign w_q_floor = 25'(w_q_prod >> FB);

  // --------------------------------------------------------------------------
  // Correction. The floor estimate is the true truncated quotient T or T-1.
  // Trying T'=est+1 and backing off when the remainder goes negative lands
  // exactly on T in both cases.
  // --------------------------------------------------------------------------
  logic [24:0] w_q_corr;
`ifdef FP_DIV_NR_CORRECT_EN
  logic [25:0]        w_qc;
  logic signed [51:0] w_rem;
  assign w_qc     = 26'(r_q) + 26'd1;
  assign w_rem    = $signed({4'b0000, w_ma, 24'b0}) - $signed(52'(w_qc) * 52'(w_mb));
  assign w_q_corr = (w_rem < 52'sd0) ? r_q : 25'(w_qc);
`else
  assign w_q_corr = r_q;
`endif

  // --------------------------------------------------------------------------
  // Normalisation, exponent and special-case selection.
  // --------------------------------------------------------------------------
  logic              w_sign;
  logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic              w_nan;
  logic signed [9:0] w_exp_base;
  logic signed [9:0] w_exp;
  logic [22:0]       w_mant;
  logic [31:0]       w_pack;

  assign w_sign   = r_a[31] ^ r_b[31];
  // Exponent field zero covers both true zero and flushed subnormals.
  assign w_a_zero = (r_a[30:23] == 8'h00);
  assign w_b_zero = (r_b[30:23] == 8'h00);
  assign w_a_inf  = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
  assign w_b_inf  = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
  assign w_a_nan  = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
  assign w_b_nan  = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);
  assign w_nan    = w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf);

  assign w_exp_base = $signed({2'b00, r_a[30:23]}) - $signed({2'b00, r_b[30:23]}) + 10'sd127;
  // Quotient in [1,2) keeps the exponent; in (0.5,1) it needs one left shift.
  assign w_exp      = r_qc[24] ? w_exp_base : (w_exp_base - 10'sd1);
  assign w_mant     = r_qc[24] ? r_qc[23:1] : r_qc[22:0];

  always_comb begin
    w_pack = {w_sign, w_exp[7:0], w_mant};
    if (w_nan) begin
      w_pack = 32'h7FC0_0000;
    end else if (w_a_inf || w_b_zero) begin
      w_pack = {w_sign, 8'hFF, 23'd0};
    end else if (w_a_zero || w_b_inf) begin
      w_pack = {w_sign, 31'd0};
    end else if (w_exp <= 10'sd0) begin
      w_pack = {w_sign, 31'd0};
    end else if (w_exp >= 10'sd255) begin
      w_pack = {w_sign, 31'h7F7F_FFFF};
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (start_i) w_state_next = SEED;
      SEED: w_state_next = ITER;
      ITER: if (r_cnt == C_ITER_LAST) w_state_next = QMUL;
      QMUL: w_state_next = CORR;
      CORR: w_state_next = PACK;
      PACK: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_x      <= '0;
      r_t      <= '0;
      r_cnt    <= 3'd0;
      r_q      <= 25'd0;
      r_qc     <= 25'd0;
      r_result <= 32'd0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_a <= a_i;
            r_b <= b_i;
          end
        end
        SEED: begin
          r_x   <= w_seed;
          r_cnt <= 3'd0;
        end
        ITER: begin
          r_cnt <= r_cnt + 3'd1;
          // Even cycles form t, odd cycles fold it back into x.
          if (r_cnt[0] == 1'b0) begin
            r_t <= w_t;
          end else begin
            r_x <= w_x_next;
          end
        end
        QMUL: r_q  <= w_q_floor;
        CORR: r_qc <= w_q_corr;
        PACK: begin
          r_result <= w_pack;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result_o = r_result;
  assign done_o   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_nr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_div_nr
//  Purpose  : Directed self-checking bench for fp_div_nr (ITERATIONS = 3).
//             Normal-result vectors accept one ulp below the exact value
//             when FP_DIV_NR_CORRECT_EN is not defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_div_nr;

  localparam int ITERS   = 3;
  localparam int LATENCY = 4 + 2 * ITERS;

  logic        clk_i;
  logic        reset_i;
  logic        start_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [31:0] result_o;
  logic        done_o;

  int n_checks;
  int n_errors;

  fp_div_nr #(.ITERATIONS(ITERS)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .result_o (result_o),
    .done_o   (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_exact(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_quot(input string tag, input logic [31:0] got, input logic [31:0] exp,
                            input bit approx);
    n_checks++;
`ifdef FP_DIV_NR_CORRECT_EN
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
`else
    assert ((got === exp) || (approx && (got === exp - 32'd1))) else begin
      n_errors++;
      $error("FAIL %s got %h expected %h (approx=%0d)", tag, got, exp, approx);
    end
`endif
  endtask

  // One division: checks latency, result, one-cycle done and held result.
  task automatic divide(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit approx);
    int cycles;
    @(negedge clk_i);
    a_i     = a;
    b_i     = b;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    cycles  = 0;
    while (done_o !== 1'b1 && cycles < 40) begin
      @(negedge clk_i);
      cycles++;
    end
    check_exact({tag, "_lat"}, 32'(cycles), 32'(LATENCY));
    check_quot({tag, "_res"}, result_o, exp, approx);
    @(negedge clk_i);
    check_exact({tag, "_donelow"}, {31'd0, done_o}, 32'd0);
    check_quot({tag, "_hold"}, result_o, exp, approx);
  endtask

  initial begin
    int pulses;
    logic [31:0] seen;
    n_checks = 0;
    n_errors = 0;
    reset_i  = 1'b1;
    start_i  = 1'b0;
    a_i      = 32'd0;
    b_i      = 32'd0;
    repeat (3) @(negedge clk_i);
    check_exact("rst_result", result_o, 32'd0);
    check_exact("rst_done", {31'd0, done_o}, 32'd0);
    reset_i = 1'b0;

    // Normal operands
    divide("one_by_two",   32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 1'b1);
    divide("one_by_three", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b1);
    divide("six_by_three", 32'h40C0_0000, 32'h4040_0000, 32'h4000_0000, 1'b1);
    divide("neg_two",      32'hC000_0000, 32'h3F80_0000, 32'hC000_0000, 1'b1);
    divide("ten_by_three", 32'h4120_0000, 32'h4040_0000, 32'h4055_5555, 1'b1);
    divide("one_by_one",   32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b1);
    divide("three",        32'h4040_0000, 32'h3F80_0000, 32'h4040_0000, 1'b1);

    // Specials and boundaries
    divide("x_by_zero",    32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0);
    divide("negx_by_zero", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b0);
    divide("zero_by_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0);
    divide("overflow",     32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F7F_FFFF, 1'b0);
    divide("nan_in",       32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0);
    divide("inf_by_inf",   32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0);
    divide("inf_by_fin",   32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0);
    divide("zero_by_fin",  32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0);
    divide("fin_by_inf",   32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, 1'b0);
    divide("subn_a",       32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0);
    divide("subn_b",       32'h3F80_0000, 32'h0040_0000, 32'h7F80_0000, 1'b0);
    divide("underflow",    32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);

    // Reset while iterating: no done, result cleared, next start works
    @(negedge clk_i);
    a_i     = 32'h3F80_0000;
    b_i     = 32'h4040_0000;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    check_exact("midrst_done", {31'd0, done_o}, 32'd0);
    check_exact("midrst_result", result_o, 32'd0);
    reset_i = 1'b0;
    pulses  = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) pulses++;
    end
    check_exact("midrst_nopulse", 32'(pulses), 32'd0);
    check_exact("midrst_result_kept", result_o, 32'd0);
    divide("after_rst", 32'h40C0_0000, 32'h4040_0000, 32'h4000_0000, 1'b1);

    // start_i held for three cycles: exactly one done pulse
    @(negedge clk_i);
    a_i     = 32'h3F80_0000;
    b_i     = 32'h4000_0000;
    start_i = 1'b1;
    repeat (3) @(negedge clk_i);
    start_i = 1'b0;
    pulses  = 0;
    seen    = 32'd0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin
        pulses++;
        seen = result_o;
      end
    end
    check_exact("longstart_pulses", 32'(pulses), 32'd1);
    check_quot("longstart_res", seen, 32'h3F00_0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
